// File: rtl/maze_run_if.sv
// rtl/maze_run_if.sv - trial sequencer handshake, gating and result signals
interface maze_run_if #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 2
);
  logic             start_i;
  logic [1:0]       ant_move_i;
  logic             hit_i;
  logic             escape_i;
  logic [1:0]       move_out_o;
  logic             ant_rst_n_o;
  logic             busy_o;
  logic             done_o;
  logic [IDX_W-1:0] trial_idx_o;
  logic             trial_done_o;
  logic             trial_escaped_o;
  logic [CNT_W-1:0] run_cycles_o;
  logic [CNT_W-1:0] best_cycles_o;
  logic [CNT_W-1:0] escape_cnt_o;
  logic [7:0]       hit_cnt_o;

  modport master (
    input  start_i, ant_move_i, hit_i, escape_i,
    output move_out_o, ant_rst_n_o, busy_o, done_o, trial_idx_o, trial_done_o,
           trial_escaped_o, run_cycles_o, best_cycles_o, escape_cnt_o, hit_cnt_o
  );

  modport slave (
    output start_i, ant_move_i, hit_i, escape_i,
    input  move_out_o, ant_rst_n_o, busy_o, done_o, trial_idx_o, trial_done_o,
           trial_escaped_o, run_cycles_o, best_cycles_o, escape_cnt_o, hit_cnt_o
  );
endinterface

// File: rtl/maze_run_ctrl.sv
// rtl/maze_run_ctrl.sv - bounded-run trial sequencer for ant_suit / maze_universe
module maze_run_ctrl #(
  parameter int RESET_CYC  = 4,
  parameter int ABORT_CYC  = 1000,
  parameter int SETTLE_CYC = 5,
  parameter int TRIALS     = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (TRIALS > 1) ? $clog2(TRIALS) : 1
) (
  input  logic       clk,
  input  logic       rst,
  maze_run_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] esc_cnt_q, esc_cnt_d;
  logic [7:0]       hit_q, hit_d;
  logic             escd_q, escd_d;
  logic             tdone_q, tdone_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             arst_n_q, arst_n_d;

  // cnt_q is shared: HOLD length, RUN cycle number (1-based), SETTLE length
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_d     = run_q;
    best_d    = best_q;
    esc_cnt_d = esc_cnt_q;
    hit_d     = hit_q;
    escd_d    = escd_q;
    tdone_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d   = S_HOLD;
          cnt_d     = CNT_W'(1);
          idx_d     = '0;
          run_d     = '0;
          best_d    = '1;
          esc_cnt_d = '0;
          hit_d     = '0;
          escd_d    = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYC)) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (bus.hit_i && hit_q != 8'hFF) hit_d = hit_q + 8'd1;
        if (bus.escape_i) begin
          state_d   = S_SETTLE;
          cnt_d     = CNT_W'(1);
          run_d     = cnt_q;
          escd_d    = 1'b1;
          esc_cnt_d = esc_cnt_q + CNT_W'(1);
          tdone_d   = 1'b1;
          if (cnt_q < best_q) best_d = cnt_q;
        end else if (cnt_q == CNT_W'(ABORT_CYC)) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(1);
          run_d   = CNT_W'(ABORT_CYC);
          escd_d  = 1'b0;
          tdone_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC)) begin
          cnt_d = CNT_W'(1);
          if (idx_q == IDX_W'(TRIALS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HOLD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_HOLD) || (state_d == S_RUN) || (state_d == S_SETTLE);
    done_d   = (state_d == S_DONE);
    arst_n_d = (state_d == S_RUN) || (state_d == S_SETTLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      best_q    <= '1;
      esc_cnt_q <= '0;
      hit_q     <= '0;
      escd_q    <= 1'b0;
      tdone_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arst_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      best_q    <= best_d;
      esc_cnt_q <= esc_cnt_d;
      hit_q     <= hit_d;
      escd_q    <= escd_d;
      tdone_q   <= tdone_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arst_n_q  <= arst_n_d;
    end
  end

  assign bus.move_out_o      = (state_q == S_RUN) ? bus.ant_move_i : 2'b00;
  assign bus.ant_rst_n_o     = arst_n_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.trial_idx_o     = idx_q;
  assign bus.trial_done_o    = tdone_q;
  assign bus.trial_escaped_o = escd_q;
  assign bus.run_cycles_o    = run_q;
  assign bus.best_cycles_o   = best_q;
  assign bus.escape_cnt_o    = esc_cnt_q;
  assign bus.hit_cnt_o       = hit_q;

endmodule

// File: tb/tb_maze_run_ctrl.sv
// tb/tb_maze_run_ctrl.sv - randomized self-checking bench for maze_run_ctrl
module tb_maze_run_ctrl;
  localparam int RC = 4, AC = 20, SC = 5, TR = 2, CW = 16, IW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  maze_run_if #(.CNT_W(CW), .IDX_W(IW)) bus ();

  maze_run_ctrl #(
    .RESET_CYC(RC), .ABORT_CYC(AC), .SETTLE_CYC(SC), .TRIALS(TR), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int exp_best, exp_esc, exp_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_move_hit();
    bus.ant_move_i = 2'($urandom_range(0, 3));
    bus.hit_i      = 1'($urandom_range(0, 1));
    #1;
  endtask

  // esc value 0 or above AC means the run is never escaped
  task automatic run_seq(input int e0, input int e1);
    int esc_at[2];
    int len;
    bit escaped;
    esc_at[0] = e0;
    esc_at[1] = e1;
    exp_best = 32'hFFFF; exp_esc = 0; exp_hits = 0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int t = 0; t < TR; t++) begin
      for (int h = 1; h <= RC; h++) begin
        rand_move_hit();
        bus.start_i = 1'($urandom_range(0, 1));
        check("hold_rst_n", bus.ant_rst_n_o, 0);
        check("hold_busy", bus.busy_o, 1);
        check("hold_idx", bus.trial_idx_o, t);
        check("hold_move", bus.move_out_o, 0);
        step();
      end
      bus.start_i = 1'b0;
      len = 0;
      escaped = 0;
      for (int k = 1; k <= AC; k++) begin
        rand_move_hit();
        check("run_rst_n", bus.ant_rst_n_o, 1);
        check("run_busy", bus.busy_o, 1);
        check("run_move", bus.move_out_o, bus.ant_move_i);
        if (bus.hit_i && exp_hits < 255) exp_hits++;
        bus.escape_i = (k == esc_at[t]);
        len = k;
        escaped = bus.escape_i;
        step();
        bus.escape_i = 1'b0;
        if (escaped) break;
      end
      if (escaped) begin
        exp_esc++;
        if (len < exp_best) exp_best = len;
      end
      check("tdone", bus.trial_done_o, 1);
      check("t_escaped", bus.trial_escaped_o, escaped);
      check("run_cycles", bus.run_cycles_o, len);
      check("best", bus.best_cycles_o, exp_best);
      check("esc_cnt", bus.escape_cnt_o, exp_esc);
      check("hit_cnt", bus.hit_cnt_o, exp_hits);
      for (int s = 1; s <= SC; s++) begin
        rand_move_hit();
        check("settle_rst_n", bus.ant_rst_n_o, 1);
        check("settle_busy", bus.busy_o, 1);
        check("settle_move", bus.move_out_o, 0);
        if (s > 1) check("settle_tdone", bus.trial_done_o, 0);
        step();
      end
    end
    bus.hit_i = 1'b0;
    check("done", bus.done_o, 1);
    check("done_busy", bus.busy_o, 0);
    check("done_rst_n", bus.ant_rst_n_o, 0);
    check("done_idx", bus.trial_idx_o, TR - 1);
    check("done_best", bus.best_cycles_o, exp_best);
    check("done_esc", bus.escape_cnt_o, exp_esc);
    check("done_hits", bus.hit_cnt_o, exp_hits);
    step();
    check("done_held", bus.done_o, 1);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.ant_move_i = 2'b11; bus.hit_i = 1'b0; bus.escape_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rst_n", bus.ant_rst_n_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_tdone", bus.trial_done_o, 0);
    check("rst_tesc", bus.trial_escaped_o, 0);
    check("rst_idx", bus.trial_idx_o, 0);
    check("rst_run", bus.run_cycles_o, 0);
    check("rst_esc", bus.escape_cnt_o, 0);
    check("rst_hits", bus.hit_cnt_o, 0);
    check("rst_best", bus.best_cycles_o, 32'hFFFF);
    check("rst_move", bus.move_out_o, 0);
    rst = 1'b0;
    step();
    check("idle_busy", bus.busy_o, 0);

    run_seq(7, 3);
    run_seq(0, 0);
    run_seq(20, 0);
    for (int i = 0; i < 6; i++) run_seq($urandom_range(1, 24), $urandom_range(1, 24));

    // mid-run reset after a few hits
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (RC) step();
    bus.hit_i = 1'b1;
    repeat (4) step();
    bus.hit_i = 1'b0;
    check("pre_rst_hits", bus.hit_cnt_o, 4);
    rst = 1'b1;
    bus.ant_move_i = 2'b11;
    #1;
    check("mr_rst_n", bus.ant_rst_n_o, 0);
    check("mr_busy", bus.busy_o, 0);
    check("mr_move", bus.move_out_o, 0);
    check("mr_hits", bus.hit_cnt_o, 0);
    check("mr_best", bus.best_cycles_o, 32'hFFFF);
    check("mr_esc", bus.escape_cnt_o, 0);
    check("mr_run", bus.run_cycles_o, 0);
    check("mr_idx", bus.trial_idx_o, 0);
    step();
    rst = 1'b0;
    step();
    step();
    check("mr_idle", bus.busy_o, 0);
    run_seq(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
